// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between an intersection controller and its environment:
// enable/request/override inputs plus the light, walk and phase indications.
interface traffic_phase_sequencer_if;
    logic       en;
    logic       ped_req;
    logic       emergency;
    logic [1:0] north_south_light;
    logic [1:0] east_west_light;
    logic       pedestrian_walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output en, ped_req, emergency,
        input  north_south_light, east_west_light, pedestrian_walk, ped_pending, phase
    );

    modport slave (
        input  en, ped_req, emergency,
        output north_south_light, east_west_light, pedestrian_walk, ped_pending, phase
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Four-way intersection phase sequencer with per-phase cycle timers,
// latched pedestrian requests, enable/freeze and an emergency all-red override.
module traffic_phase_sequencer #(
    parameter int unsigned GREEN_CYCLES  = 16,
    parameter int unsigned YELLOW_CYCLES = 4,
    parameter int unsigned ALLRED_CYCLES = 2,
    parameter int unsigned WALK_CYCLES   = 8,
    parameter int unsigned CNT_W         = 8
) (
    input logic                      clk,
    input logic                      rst,
    traffic_phase_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_A  = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_B  = 3'd5,
        WALK  = 3'd6,
        EMERG = 3'd7
    } phase_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    phase_t           state, nxt_state;
    logic [CNT_W-1:0] timer, nxt_timer;
    logic             pending;
    logic [1:0]       nxt_ns, nxt_ew;

    function automatic logic [CNT_W-1:0] load_val(input phase_t s);
        case (s)
            NS_G, EW_G: load_val = CNT_W'(GREEN_CYCLES - 1);
            NS_Y, EW_Y: load_val = CNT_W'(YELLOW_CYCLES - 1);
            WALK:       load_val = CNT_W'(WALK_CYCLES - 1);
            default:    load_val = CNT_W'(ALLRED_CYCLES - 1);
        endcase
    endfunction

    // Emergency is checked ahead of en so the override works even while frozen.
    always_comb begin
        nxt_state = state;
        nxt_timer = timer;
        if (bus.emergency) begin
            nxt_state = EMERG;
        end else if (state == EMERG) begin
            nxt_state = AR_B;
            nxt_timer = CNT_W'(ALLRED_CYCLES - 1);
        end else if (bus.en) begin
            if (timer == '0) begin
                case (state)
                    NS_G:    nxt_state = NS_Y;
                    NS_Y:    nxt_state = AR_A;
                    AR_A:    nxt_state = EW_G;
                    EW_G:    nxt_state = EW_Y;
                    EW_Y:    nxt_state = AR_B;
                    AR_B:    nxt_state = pending ? WALK : NS_G;
                    default: nxt_state = NS_G;
                endcase
                nxt_timer = load_val(nxt_state);
            end else begin
                nxt_timer = timer - CNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt_ns = RED;
        nxt_ew = RED;
        case (nxt_state)
            NS_G:    nxt_ns = GREEN;
            NS_Y:    nxt_ns = YELLOW;
            EW_G:    nxt_ew = GREEN;
            EW_Y:    nxt_ew = YELLOW;
            default: ;
        endcase
    end

    // Lights and walk are registered from the next state so they track the phase flops exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= AR_B;
            timer                 <= CNT_W'(ALLRED_CYCLES - 1);
            pending               <= 1'b0;
            bus.north_south_light <= RED;
            bus.east_west_light   <= RED;
            bus.pedestrian_walk   <= 1'b0;
        end else begin
            state                 <= nxt_state;
            timer                 <= nxt_timer;
            bus.north_south_light <= nxt_ns;
            bus.east_west_light   <= nxt_ew;
            bus.pedestrian_walk   <= (nxt_state == WALK);
            if (state != WALK && nxt_state == WALK)
                pending <= 1'b0;
            else if (state != WALK && bus.ped_req)
                pending <= 1'b1;
        end
    end

    assign bus.phase       = state;
    assign bus.ped_pending = pending;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed checks of the phase sequencer: a vector table for the basic and
// pedestrian cycles, then hand-written freeze, emergency, walk-hold and reset sequences.
module tb_traffic_phase_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_phase_sequencer_if ifc ();

    traffic_phase_sequencer #(
        .GREEN_CYCLES (4),
        .YELLOW_CYCLES(2),
        .ALLRED_CYCLES(1),
        .WALK_CYCLES  (3),
        .CNT_W        (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       ped;
        logic       emg;
        logic [2:0] ph;
        logic       pend;
    } vec_t;

    vec_t tbl[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic add(input int n, input logic r, input logic e, input logic p,
                       input logic m, input logic [2:0] ph, input logic pd);
        vec_t v;
        v.rst = r; v.en = e; v.ped = p; v.emg = m; v.ph = ph; v.pend = pd;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, then check all outputs 1 time unit after the edge.
    task automatic step(input string name, input logic r, input logic e, input logic p,
                        input logic m, input logic [2:0] ph, input logic pd);
        logic [1:0] ens, eew;
        logic       ewalk;
        rst           = r;
        ifc.en        = e;
        ifc.ped_req   = p;
        ifc.emergency = m;
        @(posedge clk);
        #1;
        ens   = (ph == 3'd0) ? 2'b10 : (ph == 3'd1) ? 2'b01 : 2'b00;
        eew   = (ph == 3'd3) ? 2'b10 : (ph == 3'd4) ? 2'b01 : 2'b00;
        ewalk = (ph == 3'd6);
        nvec++;
        if (ifc.phase !== ph || ifc.north_south_light !== ens || ifc.east_west_light !== eew ||
            ifc.pedestrian_walk !== ewalk || ifc.ped_pending !== pd) begin
            nfail++;
            $display("FAIL %s vec%0d: got phase=%0d ns=%b ew=%b walk=%b pend=%b, want phase=%0d ns=%b ew=%b walk=%b pend=%b",
                     name, nvec, ifc.phase, ifc.north_south_light, ifc.east_west_light,
                     ifc.pedestrian_walk, ifc.ped_pending, ph, ens, eew, ewalk, pd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.en        = 1'b0;
        ifc.ped_req   = 1'b0;
        ifc.emergency = 1'b0;

        // reset, then one plain cycle
        add(1, 1, 1, 0, 0, 3'd5, 0);
        add(4, 0, 1, 0, 0, 3'd0, 0);
        add(2, 0, 1, 0, 0, 3'd1, 0);
        add(1, 0, 1, 0, 0, 3'd2, 0);
        add(4, 0, 1, 0, 0, 3'd3, 0);
        add(2, 0, 1, 0, 0, 3'd4, 0);
        add(1, 0, 1, 0, 0, 3'd5, 0);
        add(1, 0, 1, 0, 0, 3'd0, 0);
        // pedestrian pulse in NS_G, served after AR_B
        add(1, 0, 1, 1, 0, 3'd0, 1);
        add(2, 0, 1, 0, 0, 3'd0, 1);
        add(2, 0, 1, 0, 0, 3'd1, 1);
        add(1, 0, 1, 0, 0, 3'd2, 1);
        add(4, 0, 1, 0, 0, 3'd3, 1);
        add(2, 0, 1, 0, 0, 3'd4, 1);
        add(1, 0, 1, 0, 0, 3'd5, 1);
        add(3, 0, 1, 0, 0, 3'd6, 0);
        add(1, 0, 1, 0, 0, 3'd0, 0);

        foreach (tbl[i])
            step("table", tbl[i].rst, tbl[i].en, tbl[i].ped, tbl[i].emg, tbl[i].ph, tbl[i].pend);

        // freeze mid EW_G: EW_G still lasts exactly 4 enabled cycles
        repeat (3) step("run_to_ewg", 0, 1, 0, 0, 3'd0, 0);
        repeat (2) step("run_to_ewg", 0, 1, 0, 0, 3'd1, 0);
        step("run_to_ewg", 0, 1, 0, 0, 3'd2, 0);
        step("ewg_first", 0, 1, 0, 0, 3'd3, 0);
        repeat (5) step("freeze", 0, 0, 0, 0, 3'd3, 0);
        repeat (3) step("ewg_rest", 0, 1, 0, 0, 3'd3, 0);
        repeat (2) step("ewy", 0, 1, 0, 0, 3'd4, 0);
        step("arb", 0, 1, 0, 0, 3'd5, 0);
        step("nsg", 0, 1, 0, 0, 3'd0, 0);

        // emergency during NS_Y with a pending request
        step("ped_set", 0, 1, 1, 0, 3'd0, 1);
        repeat (2) step("nsg_pend", 0, 1, 0, 0, 3'd0, 1);
        step("nsy_pend", 0, 1, 0, 0, 3'd1, 1);
        step("emerg_in", 0, 1, 0, 1, 3'd7, 1);
        step("emerg_hold", 0, 1, 0, 1, 3'd7, 1);
        step("emerg_en0", 0, 0, 0, 1, 3'd7, 1);
        step("emerg_rel", 0, 1, 0, 0, 3'd5, 1);

        // walk entered with ped_req high; request held through walk
        step("walk_absorb", 0, 1, 1, 0, 3'd6, 0);
        repeat (2) step("walk_held", 0, 1, 1, 0, 3'd6, 0);
        step("walk_exit", 0, 1, 1, 0, 3'd0, 0);
        step("ped_reset", 0, 1, 1, 0, 3'd0, 1);

        // reset mid EW_G
        repeat (2) step("to_ewg", 0, 1, 0, 0, 3'd0, 1);
        repeat (2) step("to_ewg", 0, 1, 0, 0, 3'd1, 1);
        step("to_ewg", 0, 1, 0, 0, 3'd2, 1);
        repeat (2) step("ewg_pre_rst", 0, 1, 0, 0, 3'd3, 1);
        step("rst_mid", 1, 1, 0, 0, 3'd5, 0);
        repeat (4) step("restart_nsg", 0, 1, 0, 0, 3'd0, 0);
        step("restart_nsy", 0, 1, 0, 0, 3'd1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
